// File: rtl/fsic_ctr_pkg.sv
// Shared definitions for the fsic counter bank: register offsets, CTRL bit
// positions, ID word and parameter legality helpers.
package fsic_ctr_pkg;

  localparam logic [3:0] OFF_CTRL  = 4'h0;
  localparam logic [3:0] OFF_COUNT = 4'h4;
  localparam logic [3:0] OFF_CMP   = 4'h8;
  localparam logic [3:0] OFF_PRE   = 4'hC;

  localparam logic [7:0] ADDR_IRQ_STAT = 8'h80;
  localparam logic [7:0] ADDR_ID       = 8'h84;

  localparam int unsigned CTRL_EN     = 0;
  localparam int unsigned CTRL_DOWN   = 1;
  localparam int unsigned CTRL_CLR    = 2;
  localparam int unsigned CTRL_IRQ_EN = 3;

  localparam logic [7:0] ID_TAG = 8'hC7;
  localparam logic [7:0] ID_REV = 8'h01;

  typedef enum logic [2:0] {
    REG_NONE,
    REG_CTRL,
    REG_COUNT,
    REG_CMP,
    REG_PRE
  } ch_reg_e;

  function automatic logic [31:0] id_word(input int unsigned nch, input int unsigned bits);
    return {ID_TAG, 8'(nch), 8'(bits), ID_REV};
  endfunction

  function automatic bit params_legal(input int unsigned nch, input int unsigned bits);
    return (nch >= 1) && (nch <= 8) && (bits >= 8) && (bits <= 32);
  endfunction

  // Byte-lane merge of a Wishbone write into an existing register value.
  function automatic logic [31:0] apply_sel(input logic [31:0] old_v,
                                            input logic [31:0] new_v,
                                            input logic [3:0]  sel);
    logic [31:0] r;
    r = old_v;
    for (int unsigned b = 0; b < 4; b++) begin
      if (sel[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/fsic_ctr_channel.sv
// One up/down counter channel with CTRL, CMP, compare-match and auto-clear.
// Optional per-channel prescaler when FSIC_CTR_PRESCALE_EN is defined.
module fsic_ctr_channel
  import fsic_ctr_pkg::*;
#(
  parameter int unsigned BITS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_ctrl,
  input  logic            wr_count,
  input  logic            wr_cmp,
  input  logic            wr_pre,
  input  logic [31:0]     wdat,
  input  logic [3:0]      wsel,
  input  logic            freeze,
  output logic [3:0]      ctrl,
  output logic [BITS-1:0] count,
  output logic [BITS-1:0] cmp,
  output logic [7:0]      pre,
  output logic            match
);

  logic [3:0]      ctrl_q, ctrl_d;
  logic [BITS-1:0] count_q, count_d;
  logic [BITS-1:0] cmp_q, cmp_d;
  logic [31:0]     ctrl_m, count_m, cmp_m;
  logic [BITS-1:0] step;
  logic            tick;
  logic            advance;

  always_comb begin
    ctrl_m  = apply_sel(32'(ctrl_q), wdat, wsel);
    count_m = apply_sel(32'(count_q), wdat, wsel);
    cmp_m   = apply_sel(32'(cmp_q), wdat, wsel);
  end

  assign step    = ctrl_q[CTRL_DOWN] ? count_q - BITS'(1) : count_q + BITS'(1);
  assign advance = ctrl_q[CTRL_EN] && !freeze && tick;

  always_comb begin
    ctrl_d  = wr_ctrl ? ctrl_m[3:0] : ctrl_q;
    cmp_d   = wr_cmp ? cmp_m[BITS-1:0] : cmp_q;
    count_d = count_q;
    match   = 1'b0;
    // A bus write to COUNT overrides counting and suppresses match for that cycle.
    if (wr_count) begin
      count_d = count_m[BITS-1:0];
    end else if (advance) begin
      match   = (step == cmp_q);
      count_d = (match && ctrl_q[CTRL_CLR]) ? '0 : step;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q  <= '0;
      count_q <= '0;
      cmp_q   <= '0;
    end else begin
      ctrl_q  <= ctrl_d;
      count_q <= count_d;
      cmp_q   <= cmp_d;
    end
  end

`ifdef FSIC_CTR_PRESCALE_EN
  logic [7:0]  pre_q, pre_d;
  logic [7:0]  psc_q, psc_d;
  logic [31:0] pre_m;

  always_comb begin
    pre_m = apply_sel(32'(pre_q), wdat, wsel);
    pre_d = wr_pre ? pre_m[7:0] : pre_q;
    tick  = (psc_q == pre_q);
    psc_d = psc_q;
    if (wr_ctrl && !ctrl_m[CTRL_EN]) begin
      psc_d = '0;
    end else if (ctrl_q[CTRL_EN] && !freeze) begin
      psc_d = tick ? '0 : psc_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q <= '0;
      psc_q <= '0;
    end else begin
      pre_q <= pre_d;
      psc_q <= psc_d;
    end
  end

  assign pre = pre_q;

  logic unused_bits;
  assign unused_bits = ^{ctrl_m[31:4], pre_m[31:8]};
`else
  assign tick = 1'b1;
  assign pre  = '0;

  logic unused_bits;
  assign unused_bits = ^{ctrl_m[31:4], wr_pre};
`endif

  assign ctrl  = ctrl_q;
  assign count = count_q;
  assign cmp   = cmp_q;

endmodule

// File: rtl/fsic_counter_bank.sv
// NCH-channel up/down counter bank behind a Caravel Wishbone slave, with W1C
// interrupt status, LA freeze/observe and GPIO mirror. Option: FSIC_CTR_PRESCALE_EN.
module fsic_counter_bank
  import fsic_ctr_pkg::*;
#(
  parameter int unsigned NCH       = 4,
  parameter int unsigned BITS      = 32,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int unsigned IO_W      = 38
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_cyc_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_dat_i,
  input  logic [31:0]       wbs_adr_i,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  input  logic [127:0]      la_data_in,
  output logic [127:0]      la_data_out,
  input  logic [127:0]      la_oenb,
  input  logic [IO_W-1:0]   io_in,
  output logic [IO_W-1:0]   io_out,
  output logic [IO_W-1:0]   io_oeb,
  output logic [2:0]        irq
);

  if (!params_legal(NCH, BITS)) begin : g_bad_params
    $error("fsic_counter_bank: NCH must be 1..8 and BITS must be 8..32");
  end

  logic            hit, acc, wr_en;
  logic [7:0]      off;
  ch_reg_e         reg_sel;
  logic [NCH-1:0]  ch_hit, wr_ctrl, wr_count, wr_cmp, wr_pre;
  logic [NCH-1:0]  freeze, match_vec, irq_en_vec, w1c;
  logic [3:0]      ctrl_v  [NCH];
  logic [BITS-1:0] count_v [NCH];
  logic [BITS-1:0] cmp_v   [NCH];
  logic [7:0]      pre_v   [NCH];
  logic [31:0]     rdata;

  logic            ack_q, ack_d;
  logic [31:0]     dat_q, dat_d;
  logic [NCH-1:0]  stat_q, stat_d;
  logic            irq_q, irq_d;
  logic [IO_W-1:0] oeb_q, oeb_d;

  assign hit   = wbs_stb_i && wbs_cyc_i && (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  assign acc   = hit && !ack_q;
  assign wr_en = acc && wbs_we_i;
  assign off   = wbs_adr_i[7:0];

  always_comb begin
    ch_hit  = '0;
    reg_sel = REG_NONE;
    if (!off[7]) begin
      for (int unsigned c = 0; c < NCH; c++) begin
        if (off[6:4] == 3'(c)) ch_hit[c] = 1'b1;
      end
      case (off[3:0])
        OFF_CTRL:  reg_sel = REG_CTRL;
        OFF_COUNT: reg_sel = REG_COUNT;
        OFF_CMP:   reg_sel = REG_CMP;
        OFF_PRE:   reg_sel = REG_PRE;
        default:   reg_sel = REG_NONE;
      endcase
    end
  end

  always_comb begin
    wr_ctrl    = '0;
    wr_count   = '0;
    wr_cmp     = '0;
    wr_pre     = '0;
    freeze     = '0;
    irq_en_vec = '0;
    for (int unsigned c = 0; c < NCH; c++) begin
      wr_ctrl[c]    = wr_en && ch_hit[c] && (reg_sel == REG_CTRL);
      wr_count[c]   = wr_en && ch_hit[c] && (reg_sel == REG_COUNT);
      wr_cmp[c]     = wr_en && ch_hit[c] && (reg_sel == REG_CMP);
      wr_pre[c]     = wr_en && ch_hit[c] && (reg_sel == REG_PRE);
      freeze[c]     = !la_oenb[c] && la_data_in[c];
      irq_en_vec[c] = ctrl_v[c][CTRL_IRQ_EN];
    end
  end

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    fsic_ctr_channel #(
      .BITS(BITS)
    ) u_ch (
      .clk      (wb_clk_i),
      .rst      (wb_rst_i),
      .wr_ctrl  (wr_ctrl[c]),
      .wr_count (wr_count[c]),
      .wr_cmp   (wr_cmp[c]),
      .wr_pre   (wr_pre[c]),
      .wdat     (wbs_dat_i),
      .wsel     (wbs_sel_i),
      .freeze   (freeze[c]),
      .ctrl     (ctrl_v[c]),
      .count    (count_v[c]),
      .cmp      (cmp_v[c]),
      .pre      (pre_v[c]),
      .match    (match_vec[c])
    );
  end

  always_comb begin
    rdata = '0;
    if (off == ADDR_IRQ_STAT) begin
      rdata = 32'(stat_q);
    end else if (off == ADDR_ID) begin
      rdata = id_word(NCH, BITS);
    end
    for (int unsigned c = 0; c < NCH; c++) begin
      if (ch_hit[c]) begin
        case (reg_sel)
          REG_CTRL:  rdata = 32'(ctrl_v[c]);
          REG_COUNT: rdata = 32'(count_v[c]);
          REG_CMP:   rdata = 32'(cmp_v[c]);
          REG_PRE:   rdata = 32'(pre_v[c]);
          default:   rdata = '0;
        endcase
      end
    end
  end

  // W1C clear is applied before OR-ing in new matches so a same-cycle set wins.
  always_comb begin
    w1c    = (wr_en && off == ADDR_IRQ_STAT) ? wbs_dat_i[NCH-1:0] : '0;
    stat_d = (stat_q & ~w1c) | match_vec;
    irq_d  = |(stat_q & irq_en_vec);
    ack_d  = acc;
    dat_d  = (acc && !wbs_we_i) ? rdata : '0;
    oeb_d  = '0;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ack_q  <= 1'b0;
      dat_q  <= '0;
      stat_q <= '0;
      irq_q  <= 1'b0;
      oeb_q  <= '1;
    end else begin
      ack_q  <= ack_d;
      dat_q  <= dat_d;
      stat_q <= stat_d;
      irq_q  <= irq_d;
      oeb_q  <= oeb_d;
    end
  end

  assign wbs_ack_o   = ack_q;
  assign wbs_dat_o   = dat_q;
  assign irq         = {2'b00, irq_q};
  assign la_data_out = 128'(count_v[0]);
  assign io_out      = IO_W'(count_v[0]);
  assign io_oeb      = oeb_q;

  logic unused_inputs;
  assign unused_inputs = ^{io_in, la_data_in[127:NCH], la_oenb[127:NCH]};

endmodule

// File: tb/tb_fsic_counter_bank.sv
// Scoreboard bench for fsic_counter_bank: expected read data is queued when a
// read is issued and compared when the DUT acks.
module tb_fsic_counter_bank;

  localparam logic [31:0] BASE = 32'h3000_0000;

  logic         wb_clk_i = 1'b0;
  logic         wb_rst_i;
  logic         wbs_stb_i, wbs_cyc_i, wbs_we_i;
  logic [3:0]   wbs_sel_i;
  logic [31:0]  wbs_dat_i, wbs_adr_i;
  logic         wbs_ack_o;
  logic [31:0]  wbs_dat_o;
  logic [127:0] la_data_in, la_data_out, la_oenb;
  logic [37:0]  io_in, io_out, io_oeb;
  logic [2:0]   irq;

  fsic_counter_bank #(
    .NCH(4),
    .BITS(32),
    .BASE_ADDR(BASE),
    .IO_W(38)
  ) dut (
    .wb_clk_i    (wb_clk_i),
    .wb_rst_i    (wb_rst_i),
    .wbs_stb_i   (wbs_stb_i),
    .wbs_cyc_i   (wbs_cyc_i),
    .wbs_we_i    (wbs_we_i),
    .wbs_sel_i   (wbs_sel_i),
    .wbs_dat_i   (wbs_dat_i),
    .wbs_adr_i   (wbs_adr_i),
    .wbs_ack_o   (wbs_ack_o),
    .wbs_dat_o   (wbs_dat_o),
    .la_data_in  (la_data_in),
    .la_data_out (la_data_out),
    .la_oenb     (la_oenb),
    .io_in       (io_in),
    .io_out      (io_out),
    .io_oeb      (io_oeb),
    .irq         (irq)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  int cyc_n = 0;
  always @(posedge wb_clk_i) cyc_n <= cyc_n + 1;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Commit edge of an access issued now: one edge, or two if ack is still high.
  function automatic int next_edge();
    return wbs_ack_o ? cyc_n + 2 : cyc_n + 1;
  endfunction

  task automatic wb_xfer(input logic [31:0] adr, input logic wr, input logic [31:0] dat,
                         input logic [3:0] sel, input string tag, output int edge_n);
    int due;
    logic [31:0] expv;
    due       = next_edge();
    wbs_adr_i = adr;
    wbs_we_i  = wr;
    wbs_dat_i = dat;
    wbs_sel_i = sel;
    wbs_stb_i = 1'b1;
    wbs_cyc_i = 1'b1;
    edge_n    = -1;
    for (int i = 0; i < 8; i++) begin
      @(posedge wb_clk_i); #1;
      if (wbs_ack_o) begin
        edge_n = cyc_n;
        break;
      end
    end
    wbs_stb_i = 1'b0;
    wbs_cyc_i = 1'b0;
    wbs_we_i  = 1'b0;
    check({tag, "_ack_edge"}, 128'(edge_n), 128'(due));
    if (!wr) begin
      expv = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
      check(tag, 128'(wbs_dat_o), 128'(expv));
    end
  endtask

  task automatic wb_wr(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                       input string tag, output int edge_n);
    wb_xfer(BASE | adr, 1'b1, dat, sel, tag, edge_n);
  endtask

  task automatic wb_rd(input logic [31:0] adr, input logic [31:0] expv, input string tag);
    int e;
    exp_q.push_back(expv);
    wb_xfer(BASE | adr, 1'b0, 32'h0, 4'hF, tag, e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, w1, w2, d1, d2, c, f, s, e, p;
    logic [31:0] v, pre;
    logic [37:0] ones38;
    ones38 = '1;

    wb_rst_i = 1'b1; wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
    wbs_sel_i = '0; wbs_dat_i = '0; wbs_adr_i = '0;
    la_data_in = '0; la_oenb = '1; io_in = '0;

    repeat (3) @(posedge wb_clk_i);
    #1;
    check("rst_ack", 128'(wbs_ack_o), 128'(0));
    check("rst_dat", 128'(wbs_dat_o), 128'(0));
    check("rst_irq", 128'(irq), 128'(0));
    check("rst_oeb", 128'(io_oeb), 128'(ones38));
    check("rst_la", la_data_out, 128'(0));
    check("rst_io", 128'(io_out), 128'(0));
    wb_rst_i = 1'b0;
    @(posedge wb_clk_i); #1;
    check("oeb_release", 128'(io_oeb), 128'(0));

    wb_rd(32'h84, 32'hC704_2001, "id");
    @(posedge wb_clk_i); #1;
    check("dat_idle", 128'(wbs_dat_o), 128'(0));

    // Register behaviour on channel 3 and unmapped space
    wb_wr(32'h30, 32'hFFFF_FFF6, 4'hF, "ctrl3_wr", e);
    wb_rd(32'h30, 32'h0000_0006, "ctrl3_rd");
    wb_wr(32'h38, 32'h1234_5678, 4'b1100, "cmp3_wr", e);
    wb_rd(32'h38, 32'h1234_0000, "cmp3_sel");
    wb_wr(32'h3C, 32'h0000_00FF, 4'hF, "pre3_wr", e);
`ifdef FSIC_CTR_PRESCALE_EN
    wb_rd(32'h3C, 32'h0000_00FF, "pre3_rd");
`else
    wb_rd(32'h3C, 32'h0000_0000, "rsvd3_rd");
`endif
    wb_wr(32'h40, 32'hFFFF_FFFF, 4'hF, "ch4_wr", e);
    wb_rd(32'h40, 32'h0, "ch4_rd");
    wb_rd(32'h90, 32'h0, "unmapped_rd");

    // Outside the window: no ack, no side effect on the aliased COUNT3
    wbs_adr_i = BASE | 32'h134; wbs_dat_i = 32'h55; wbs_we_i = 1'b1;
    wbs_sel_i = 4'hF; wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge wb_clk_i); #1;
      check("nohit_ack", 128'(wbs_ack_o), 128'(0));
    end
    wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
    wb_rd(32'h34, 32'h0, "nohit_count3");

    // Channel 0: compare match at 5 with irq enabled
    wb_wr(32'h08, 32'd5, 4'hF, "cmp0_wr", e);
    wb_wr(32'h00, 32'h9, 4'hF, "ctrl0_wr", w0);
    for (int k = 1; k <= 7; k++) begin
      @(posedge wb_clk_i); #1;
      check("c0_la", la_data_out, 128'(k));
      check("c0_io", 128'(io_out), 128'(k));
      check("c0_irq", 128'(irq), 128'(k >= 6 ? 1 : 0));
    end
    wb_rd(32'h80, 32'h1, "stat_c0");
    wb_wr(32'h80, 32'h1, 4'hF, "w1c_c0", c);
    check("w1c_irq_lag", 128'(irq), 128'(1));
    @(posedge wb_clk_i); #1;
    check("w1c_irq_low", 128'(irq), 128'(0));

    // Channel 1: down-count wraps below zero
    wb_wr(32'h10, 32'h3, 4'hF, "ctrl1_wr", w1);
    @(posedge wb_clk_i); #1;
    e = next_edge();
    wb_rd(32'h14, 32'(0) - 32'(e - 1 - w1), "c1_wrap");
    wb_wr(32'h10, 32'h2, 4'hF, "ctrl1_stop", d1);
    wb_rd(32'h14, 32'(0) - 32'(d1 - w1), "c1_held");

    // Channel 2: clear on match at 3 gives a period-3 sequence
    wb_wr(32'h28, 32'd3, 4'hF, "cmp2_wr", e);
    wb_wr(32'h20, 32'h5, 4'hF, "ctrl2_wr", w2);
    for (int i = 0; i < 4; i++) begin
      e = next_edge();
      wb_rd(32'h24, 32'((e - 1 - w2) % 3), "c2_seq");
    end
    wb_rd(32'h80, 32'h4, "stat_c2");
    wb_wr(32'h20, 32'h4, 4'hF, "ctrl2_stop", d2);
    wb_rd(32'h24, 32'((d2 - w2) % 3), "c2_held");

    // Channel 0 freeze through the LA for 10 cycles
    f = cyc_n;
    la_oenb[0] = 1'b0; la_data_in[0] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge wb_clk_i); #1;
      check("frz_hold", la_data_out, 128'(32'(f - w0)));
    end
    la_oenb[0] = 1'b1; la_data_in[0] = 1'b0;
    @(posedge wb_clk_i); #1;
    check("frz_resume", la_data_out, 128'(32'(f - w0 + 1)));

    // Byte-lane COUNT write during counting, then match colliding with W1C
    e   = next_edge();
    pre = 32'(e - 1 - w0 - 10);
    v   = {pre[31:8], 8'hAA};
    wb_wr(32'h04, 32'h0000_00AA, 4'b0001, "count0_sel", s);
    check("sel_la", la_data_out, 128'(v));
    wb_wr(32'h08, v + 32'd6, 4'hF, "cmp0_rearm", p);
    repeat (3) @(posedge wb_clk_i);
    #1;
    wb_wr(32'h80, 32'h5, 4'hF, "w1c_collide", c);
    check("collide_edge", 128'(c), 128'(s + 6));
    check("collide_irq_lag", 128'(irq), 128'(0));
    wb_rd(32'h80, 32'h1, "stat_set_wins");
    check("collide_irq", 128'(irq), 128'(1));

    // Reset in the middle of an access
    wbs_adr_i = BASE | 32'h84; wbs_we_i = 1'b0; wbs_sel_i = 4'hF;
    wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wb_rst_i = 1'b1;
    @(posedge wb_clk_i); #1;
    check("mid_rst_ack", 128'(wbs_ack_o), 128'(0));
    check("mid_rst_dat", 128'(wbs_dat_o), 128'(0));
    check("mid_rst_irq", 128'(irq), 128'(0));
    check("mid_rst_la", la_data_out, 128'(0));
    check("mid_rst_oeb", 128'(io_oeb), 128'(ones38));
    @(posedge wb_clk_i); #1;
    wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wb_rst_i = 1'b0;
    @(posedge wb_clk_i); #1;
    wb_rd(32'h00, 32'h0, "post_rst_ctrl0");
    wb_rd(32'h04, 32'h0, "post_rst_count0");
    wb_rd(32'h80, 32'h0, "post_rst_stat");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fsic_counter_bank.md
Name: fsic_counter_bank

Overview:
- Parametrised successor to the single-counter user-project example: NCH independent up/down counters behind a Caravel Wishbone slave.
- Adds per-channel compare match, auto-clear, a W1C interrupt status register, Logic Analyzer (LA) freeze control and a GPIO mirror of channel 0.
- Instantiated inside user_project_wrapper in place of the example project; uses the same Wishbone, LA, IO and irq pin set.

Parameters:
- NCH, 4, number of counter channels; legal range 1..8.
- BITS, 32, counter width; legal range 8..32.
- BASE_ADDR, 32'h3000_0000, Wishbone window base; bits [31:8] are decoded.
- IO_W, 38, GPIO width, equal to `MPRJ_IO_PADS.

Ports:
- wb_clk_i  in  1  sole clock.
- wb_rst_i  in  1  reset; synchronous, active-high.
- wbs_stb_i, wbs_cyc_i, wbs_we_i  in  1 each  Wishbone strobe, cycle, write enable.
- wbs_sel_i  in  4  byte selects.
- wbs_adr_i, wbs_dat_i  in  32 each  address, write data.
- wbs_ack_o  out  1  acknowledge.
- wbs_dat_o  out  32  read data.
- la_data_in, la_oenb  in  128 each  LA data and LA output-enable (active low).
- la_data_out  out  128  LA observe bus.
- io_in  in  IO_W  unused.
- io_out, io_oeb  out  IO_W each  GPIO data and output-enable (active low).
- irq  out  3  user interrupts.

Behaviour:
- Decode: hit = stb & cyc & (adr[31:8]==BASE_ADDR[31:8]). No hit means no ack and no side effects.
- Ack: registered. Asserts 1 cycle after a hit with ack low, for exactly 1 cycle; back-to-back accesses therefore take 2 cycles each. Writes commit on the edge that raises ack. wbs_dat_o is valid while ack is high and is 0 otherwise.
- Register map, channel c at offset 0x10*c:
  - +0x0 CTRL: [0] en, [1] down, [2] clr_on_match, [3] irq_en. Other bits read 0.
  - +0x4 COUNT: RW.
  - +0x8 CMP: RW.
  - +0xC: reserved; see Optional Feature.
- Global registers:
  - 0x80 IRQ_STAT[NCH-1:0]: write-1-to-clear.
  - 0x84 ID: read-only {8'hC7, 8'(NCH), 8'(BITS), 8'h01}.
- Unmapped offsets inside the window ack, read 0 and ignore writes. Channels >= NCH count as unmapped.
- Byte selects apply to CTRL, COUNT and CMP. Register bits above BITS read 0.
- Counting:
  - Channel advances when en=1 and it is not frozen.
  - Frozen means la_oenb[c]==0 and la_data_in[c]==1.
  - next = count±1 modulo 2^BITS, so it wraps both ways.
- Match: computed on next == CMP.
  - Sets IRQ_STAT[c] on the same edge.
  - If clr_on_match, count loads 0 instead of next.
  - A disabled or frozen channel never matches.
- Simultaneous events:
  - A WB write to COUNT beats counting. Unselected bytes keep the pre-update value. No match is evaluated that cycle.
  - A set and a W1C on the same IRQ_STAT bit in one cycle: set wins.
- irq[0] = |(IRQ_STAT & irq_en vector), registered, so it follows a status change by 1 cycle. irq[2:1] = 0.
- la_data_out[BITS-1:0] = count of channel 0; all other LA bits 0.
- GPIO: io_out[min(BITS,IO_W)-1:0] = count of channel 0; remaining bits 0. io_oeb is registered: all 1s in reset, all 0s from the first cycle after reset deasserts.
- Reset, including mid-transaction:
  - All CTRL, COUNT, CMP and IRQ_STAT clear to 0.
  - ack, dat_o, irq go low; la_data_out and io_out go to 0.
  - Any in-flight access is dropped without an ack.

Optional Feature:
- FSIC_CTR_PRESCALE_EN
- Defined: offset +0xC is PRE[7:0] per channel (RW, reset 0). A channel advances only when its private prescale counter reaches PRE, then that counter reloads to 0. PRE=0 means every cycle. Writing CTRL.en=0 resets the prescale counter.
- Undefined: +0xC reads 0 and ignores writes; channels advance every cycle.

Decomposition:
- Package fsic_ctr_pkg: register offset constants, CTRL bit indices, ID constant, NCH/BITS legality checks.
- Sub-module fsic_ctr_channel: one counter with its CTRL, CMP, match logic and optional prescaler, generated NCH times.
- Top level owns Wishbone decode, ack and read mux, IRQ_STAT, LA and GPIO.

Test Plan:
- Reset then read ID at 0x3000_0084 -> 0xC7042001; ack exactly 1 cycle after stb; io_oeb goes from all 1s to 0.
- Write CMP0=5, CTRL0=0x9 -> IRQ_STAT=0x1 on the edge where COUNT0 becomes 5; irq[0] high the next cycle; W1C 0x1 -> irq[0] low 1 cycle later.
- CTRL1=0x3 with COUNT1=0 -> COUNT1 reads 0xFFFF_FFFF, then 0xFFFF_FFFE (down-count wrap).
- CTRL2=0x5, CMP2=3 -> COUNT2 sequence 1,2,0,1,2,0…; each 3→0 reload sets IRQ_STAT[2].
- la_oenb[0]=0, la_data_in[0]=1 for 10 cycles -> COUNT0 holds; releasing the freeze resumes counting; la_data_out tracks COUNT0.
- Write COUNT0 with sel=4'b0001, data 0xAA, during counting -> low byte = 0xAA, upper bytes = pre-update value; a simultaneous match and W1C on IRQ_STAT -> status bit stays set.
